triplet_source_3bit: RTL and testbench

//  Stimulus/transmit end for the 3-bit two-of-three window checker: sequentially emits every
//  (a,b,c) triple of 3-bit values over a valid/ready handshake, each with a reference flag exp_out.
//  exp_out = 1 when at least two of a,b,c lie in [LO_VAL,HI_VAL]. Also keeps sent and match counts.

---
 rtl/triplet_source_3bit_if.sv | 20 ++
 rtl/triplet_source_3bit.sv | 130 +++++++++++++
 tb/tb_triplet_source_3bit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/triplet_source_3bit_if.sv
// Triple transmit handshake between the triplet source and the window checker.
// Master drives the triple and its reference flag; slave returns ready.
interface triplet_source_3bit_if;
  logic       valid;
  logic       ready;
  logic [2:0] a_out;
  logic [2:0] b_out;
  logic [2:0] c_out;
  logic       exp_out;

  modport master (
    output valid, a_out, b_out, c_out, exp_out,
    input  ready
  );

  modport slave (
    input  valid, a_out, b_out, c_out, exp_out,
    output ready
  );
endinterface

// File: rtl/triplet_source_3bit.sv
// Sweeps every 3-bit (a,b,c) triple with a two-of-three window reference flag.
// Optional TRIPLET_SRC_LFSR_EN: LFSR index order instead of ascending count.
module triplet_source_3bit #(
  parameter int LO_VAL = 3,
  parameter int HI_VAL = 4,
  parameter int REPEAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  triplet_source_3bit_if.master        tx,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  sent_cnt,
  output logic [15:0]                  match_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

`ifdef TRIPLET_SRC_LFSR_EN
  localparam logic [8:0] FIRST = 9'h001;
  localparam logic [8:0] LAST  = 9'h000;
`else
  localparam logic [8:0] FIRST = 9'h000;
  localparam logic [8:0] LAST  = 9'h1FF;
`endif

  localparam logic [6:0] SW_LAST = 7'(REPEAT - 1);

  state_t     state;
  logic [8:0] idx;
  logic [6:0] sweep;
  logic [8:0] nidx;
  logic [8:0] upd;
  logic       wrap;
  logic       more;
  logic       xfer;

`ifdef TRIPLET_SRC_LFSR_EN
  // 0x100 is the last nonzero state before the seed; 0x000 closes the sweep
  function automatic logic [8:0] next_idx(input logic [8:0] i);
    if (i == 9'h100) return 9'h000;
    return {i[7:0], i[8] ^ i[4]};
  endfunction
`else
  function automatic logic [8:0] next_idx(input logic [8:0] i);
    return i + 9'd1;
  endfunction
`endif

  function automatic logic in_win(input logic [2:0] x);
    return (int'(x) >= LO_VAL) && (int'(x) <= HI_VAL);
  endfunction

  function automatic logic exp_of(input logic [8:0] i);
    logic [1:0] n;
    n = 2'(in_win(i[8:6])) + 2'(in_win(i[5:3]))
      + 2'(in_win(i[2:0]));
    return n >= 2'd2;
  endfunction

  always_comb begin
    nidx = next_idx(idx);
    wrap = (idx == LAST);
    more = (sweep != SW_LAST);
    upd  = wrap ? FIRST : nidx;
    xfer = tx.valid && tx.ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 9'h000;
      sweep      <= 7'd0;
      tx.valid   <= 1'b0;
      tx.a_out   <= 3'd0;
      tx.b_out   <= 3'd0;
      tx.c_out   <= 3'd0;
      tx.exp_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_cnt   <= 16'd0;
      match_cnt  <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= RUN;
            idx        <= FIRST;
            sweep      <= 7'd0;
            sent_cnt   <= 16'd0;
            match_cnt  <= 16'd0;
            tx.valid   <= 1'b1;
            busy       <= 1'b1;
            {tx.a_out, tx.b_out, tx.c_out} <= FIRST;
            tx.exp_out <= exp_of(FIRST);
          end
        end
        RUN: begin
          if (xfer) begin
            sent_cnt  <= sent_cnt + 16'd1;
            match_cnt <= match_cnt + 16'(tx.exp_out);
            if (wrap && !more) begin
              state    <= FIN;
              tx.valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              if (wrap) sweep <= sweep + 7'd1;
              idx        <= upd;
              {tx.a_out, tx.b_out, tx.c_out} <= upd;
              tx.exp_out <= exp_of(upd);
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triplet_source_3bit.sv
// Scoreboard bench for triplet_source_3bit: queued expected triples,
// negedge monitor, directed runs incl. backpressure, abort and REPEAT=2.
module tb_triplet_source_3bit;

  logic clk = 1'b0;
  logic rst, start, start2;
  logic busy, done, busy2, done2, busy3, done3;
  logic [15:0] sent_cnt, match_cnt;
  logic [15:0] sent2, match2, sent3, match3;

  triplet_source_3bit_if bus ();
  triplet_source_3bit_if bus2 ();
  triplet_source_3bit_if bus3 ();

  triplet_source_3bit dut (
    .clk(clk), .rst(rst), .start(start), .tx(bus),
    .busy(busy), .done(done),
    .sent_cnt(sent_cnt), .match_cnt(match_cnt)
  );

  triplet_source_3bit #(.LO_VAL(3), .HI_VAL(4), .REPEAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .tx(bus2),
    .busy(busy2), .done(done2),
    .sent_cnt(sent2), .match_cnt(match2)
  );

  triplet_source_3bit #(.LO_VAL(0), .HI_VAL(7), .REPEAT(1)) dut3 (
    .clk(clk), .rst(rst), .start(start2), .tx(bus3),
    .busy(busy3), .done(done3),
    .sent_cnt(sent3), .match_cnt(match3)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  logic [9:0] q[$];
  logic [9:0] obs[512];
  int nobs = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  int done3_cnt = 0;
  int k2 = 0;
  int bad2 = 0;
  logic [8:0] model_seq[512];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  function automatic logic win(input logic [2:0] x, input int lo,
                               input int hi);
    return (int'(x) >= lo) && (int'(x) <= hi);
  endfunction

  function automatic logic [9:0] entry(input logic [8:0] i);
    int n;
    n = int'(win(i[8:6], 3, 4)) + int'(win(i[5:3], 3, 4))
      + int'(win(i[2:0], 3, 4));
    return {i, n >= 2};
  endfunction

  task automatic push_run();
    for (int k = 0; k < 512; k++) q.push_back(entry(model_seq[k]));
  endtask

  // dut1 scoreboard monitor
  always @(negedge clk) begin
    logic [9:0] got, e;
    if (done) done_cnt++;
    if (bus.valid && bus.ready) begin
      got = {bus.a_out, bus.b_out, bus.c_out, bus.exp_out};
      if (q.size() == 0) begin
        total++;
        $display("FAIL extra_triple: got %0h required none", got);
      end else begin
        e = q.pop_front();
        chk("triple", 32'(got), 32'(e));
        if (nobs < 512) begin
          obs[nobs] = got;
          nobs++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done2) done2_cnt++;
    if (done3) done3_cnt++;
    if (bus2.valid && bus2.ready) begin
      if ({bus2.a_out, bus2.b_out, bus2.c_out} != model_seq[k2 % 512])
        bad2++;
      k2++;
    end
  end

  task automatic pulse(input bit two);
    @(posedge clk); #1;
    if (two) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input bit two, input int lim,
                           output int lat);
    bit hit;
    hit = 0;
    lat = 0;
    while (!hit && lat < lim) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      hit = two ? done2 : done;
    end
    if (!hit) begin
      total++;
      $display("FAIL done_timeout: got none required done");
    end
  endtask

  task automatic wait_sent(input logic [15:0] n);
    bit hit;
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (sent_cnt == n);
    end
    if (!hit) begin
      total++;
      $display("FAIL sent_timeout: got %0d required %0d", sent_cnt, n);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int distinct;
    bit seen[512];
    logic [8:0] s;
`ifdef TRIPLET_SRC_LFSR_EN
    s = 9'h001;
    for (int k = 0; k < 511; k++) begin
      model_seq[k] = s;
      s = {s[7:0], s[8] ^ s[4]};
    end
    model_seq[511] = 9'h000;
`else
    for (int k = 0; k < 512; k++) model_seq[k] = 9'(k);
`endif
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    bus.ready = 1'b0;
    bus2.ready = 1'b1;
    bus3.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sent", 32'(sent_cnt), 0);
    chk("rst_match", 32'(match_cnt), 0);
    chk("rst_abce", 32'({bus.a_out, bus.b_out, bus.c_out, bus.exp_out}), 0);

    // full sweep, ready always high
    bus.ready = 1'b1;
    nobs = 0;
    done_cnt = 0;
    push_run();
    pulse(0);
    wait_done(0, 700, lat);
    chk("start_to_done", 32'(lat), 512);
    chk("sent_512", 32'(sent_cnt), 512);
    chk("match_80", 32'(match_cnt), 80);
    chk("done_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt), 1);
    chk("idle_valid", 32'(bus.valid), 0);
    chk("hold_sent", 32'(sent_cnt), 512);
    chk("queue_empty", 32'(q.size()), 0);
    distinct = 0;
    for (int k = 0; k < 512; k++) seen[k] = 0;
    for (int k = 0; k < nobs; k++) begin
      if (!seen[obs[k][9:1]]) distinct++;
      seen[obs[k][9:1]] = 1;
    end
    chk("distinct", 32'(distinct), 512);
`ifdef TRIPLET_SRC_LFSR_EN
    chk("lfsr_first", 32'(obs[0]), 32'({3'd0, 3'd0, 3'd1, 1'b0}));
    chk("lfsr_second", 32'(obs[1]), 32'({3'd0, 3'd0, 3'd2, 1'b0}));
    chk("lfsr_last", 32'(obs[511]), 32'({3'd0, 3'd0, 3'd0, 1'b0}));
`else
    chk("spot_000", 32'(obs[9'h000]), 32'({3'd0, 3'd0, 3'd0, 1'b0}));
    chk("spot_0db", 32'(obs[9'h0DB]), 32'({3'd3, 3'd3, 3'd3, 1'b1}));
    chk("spot_0e5", 32'(obs[9'h0E5]), 32'({3'd3, 3'd4, 3'd5, 1'b1}));
    chk("spot_1c0", 32'(obs[9'h1C0]), 32'({3'd7, 3'd0, 3'd0, 1'b0}));
    chk("spot_127", 32'(obs[9'h127]), 32'({3'd4, 3'd4, 3'd7, 1'b1}));
`endif

    // backpressure at the 11th triple
    push_run();
    pulse(0);
    wait_sent(16'd10);
    bus.ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("frozen_abce",
          32'({bus.a_out, bus.b_out, bus.c_out, bus.exp_out}),
          32'(entry(model_seq[10])));
      chk("frozen_sent", 32'(sent_cnt), 10);
      @(posedge clk);
    end
    #1 bus.ready = 1'b1;
    wait_done(0, 700, lat);
    chk("bp_sent", 32'(sent_cnt), 512);
    chk("bp_match", 32'(match_cnt), 80);

    // start ignored in RUN, then reset mid-run
    push_run();
    pulse(0);
    wait_sent(16'd50);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_ignored", 32'(sent_cnt), 51);
    wait_sent(16'd100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_valid", 32'(bus.valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sent", 32'(sent_cnt), 0);
    chk("abort_match", 32'(match_cnt), 0);
    repeat (2) @(negedge clk);
    chk("abort_idle", 32'(bus.valid), 0);
    push_run();
    pulse(0);
    wait_done(0, 700, lat);
    chk("restart_lat", 32'(lat), 512);
    chk("restart_sent", 32'(sent_cnt), 512);

    // REPEAT=2 and full-window instances
    done2_cnt = 0;
    done3_cnt = 0;
    k2 = 0;
    bad2 = 0;
    pulse(1);
    wait_done(1, 1200, lat);
    repeat (3) @(negedge clk);
    chk("r2_lat", 32'(lat), 1024);
    chk("r2_count", 32'(k2), 1024);
    chk("r2_order", 32'(bad2), 0);
    chk("r2_sent", 32'(sent2), 1024);
    chk("r2_match", 32'(match2), 160);
    chk("r2_done_once", 32'(done2_cnt), 1);
    chk("win07_sent", 32'(sent3), 512);
    chk("win07_match", 32'(match3), 512);
    chk("win07_done_once", 32'(done3_cnt), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
